// File: rtl/run_length_detector_if.sv
// run_length_detector_if
//   Bundles the control, data and status signals of run_length_detector.
//   CLK and RST stay plain ports on the module.
//
// Handshake: EN is a valid-only strobe with no ready/backpressure. A sample
//   is accepted on any CLK edge where EN=1 and CLR=0. The detector is
//   always ready, so the master may present a new bit every cycle.
//
// Signals (master = stream source / status consumer, slave = detector):
//   CLR          m->s  synchronous clear, wins over EN
//   EN           m->s  DATA valid this cycle
//   DATA         m->s  serial data bit
//   RUN_LEN      m->s  detection threshold (only sampled while idle)
//   OUT          s->m  00 none, 01 zero-run detected, 10 one-run detected
//   HIT          s->m  one-cycle pulse when a run first reaches threshold
//   RUN_CNT      s->m  current run length, saturating at MAX_RUN
//   ZERO_EVT_CNT s->m  saturating count of zero-run detections
//   ONE_EVT_CNT  s->m  saturating count of one-run detections
//   state_dbg    s->m  FSM state for debug/checkers (0 idle, 1 run, 2 det)
interface run_length_detector_if #(
  parameter int MAX_RUN = 8,
  parameter int EVT_W   = 8
);
  localparam int CNT_W = $clog2(MAX_RUN + 1);

  logic             CLR;
  logic             EN;
  logic             DATA;
  logic [CNT_W-1:0] RUN_LEN;
  logic [1:0]       OUT;
  logic             HIT;
  logic [CNT_W-1:0] RUN_CNT;
  logic [EVT_W-1:0] ZERO_EVT_CNT;
  logic [EVT_W-1:0] ONE_EVT_CNT;
  logic [1:0]       state_dbg;

  modport master (
    output CLR, EN, DATA, RUN_LEN,
    input  OUT, HIT, RUN_CNT, ZERO_EVT_CNT, ONE_EVT_CNT, state_dbg
  );

  modport slave (
    input  CLR, EN, DATA, RUN_LEN,
    output OUT, HIT, RUN_CNT, ZERO_EVT_CNT, ONE_EVT_CNT, state_dbg
  );
endinterface

// File: rtl/run_length_detector.sv
// run_length_detector
//   Watches a qualified serial bit stream and flags when a run of identical
//   bits reaches a programmable threshold (1..MAX_RUN). Reports the current
//   run length, a one-cycle HIT pulse and per-polarity saturating event
//   counts. All outputs are registered.
//
// Ports:
//   CLK  system clock, all state on posedge
//   RST  asynchronous active-low reset
//   bus  run_length_detector_if.slave (control in, status out)
module run_length_detector #(
  parameter int MAX_RUN = 8,
  parameter int EVT_W   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  run_length_detector_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_RUN + 1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_RUN);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DET  = 2'd2
  } state_t;

  state_t           state;
  logic             last_bit;
  logic [CNT_W-1:0] thr;
  logic [CNT_W-1:0] run_cnt;
  logic [1:0]       out_q;
  logic             hit_q;
  logic [EVT_W-1:0] zero_evt;
  logic [EVT_W-1:0] one_evt;

  logic [CNT_W-1:0] thr_in;
  logic [CNT_W-1:0] thr_use;
  logic             same;
  logic [CNT_W-1:0] cnt_next;
  logic             reach;
  logic             hit_next;

  always_comb begin
    thr_in = bus.RUN_LEN;
    if (bus.RUN_LEN == '0)
      thr_in = ONE_C;
    else if (bus.RUN_LEN > MAX_C)
      thr_in = MAX_C;

    // The first sample of a run from IDLE is judged against the threshold
    // being loaded in that same cycle, so a RUN_LEN set while idle applies
    // to the very first bit.
    thr_use = (state == IDLE) ? thr_in : thr;

    same     = (state != IDLE) && (bus.DATA == last_bit);
    cnt_next = ONE_C;
    if (same)
      cnt_next = (run_cnt == MAX_C) ? MAX_C : run_cnt + ONE_C;
    reach    = (cnt_next >= thr_use);
    // A saturated run that already sits at the threshold must not re-fire.
    hit_next = (cnt_next == thr_use) && !(same && (run_cnt == thr_use));
  end

  // Threshold follows RUN_LEN while idle and is frozen once a run starts.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      thr <= ONE_C;
    else if (state == IDLE)
      thr <= thr_in;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      last_bit <= 1'b0;
      run_cnt  <= '0;
      out_q    <= 2'b00;
      hit_q    <= 1'b0;
      zero_evt <= '0;
      one_evt  <= '0;
    end else if (bus.CLR) begin
      state    <= IDLE;
      run_cnt  <= '0;
      out_q    <= 2'b00;
      hit_q    <= 1'b0;
      zero_evt <= '0;
      one_evt  <= '0;
    end else if (bus.EN) begin
      case (state)
        IDLE, RUN, DET: begin
          last_bit <= bus.DATA;
          run_cnt  <= cnt_next;
          state    <= reach ? DET : RUN;
          out_q    <= reach ? (bus.DATA ? 2'b10 : 2'b01) : 2'b00;
          hit_q    <= hit_next;
          if (hit_next) begin
            if (bus.DATA) begin
              if (one_evt != '1) one_evt <= one_evt + 1'b1;
            end else begin
              if (zero_evt != '1) zero_evt <= zero_evt + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          run_cnt <= '0;
          out_q   <= 2'b00;
          hit_q   <= 1'b0;
        end
      endcase
    end else begin
      hit_q <= 1'b0;
    end
  end

  assign bus.OUT          = out_q;
  assign bus.HIT          = hit_q;
  assign bus.RUN_CNT      = run_cnt;
  assign bus.ZERO_EVT_CNT = zero_evt;
  assign bus.ONE_EVT_CNT  = one_evt;
  assign bus.state_dbg    = state;
endmodule

// File: tb/tb_run_length_detector.sv
// tb_run_length_detector
//   Drives run_length_detector with directed scenarios and a randomized
//   stream, comparing every cycle against a run-length model that tracks an
//   unbounded run length and applies the detection rules arithmetically.
module tb_run_length_detector;
  localparam int MAX_RUN = 8;
  localparam int EVT_W   = 8;
  localparam int CNT_W   = $clog2(MAX_RUN + 1);
  localparam int EVT_MAX = (1 << EVT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  run_length_detector_if #(.MAX_RUN(MAX_RUN), .EVT_W(EVT_W)) bus ();

  run_length_detector #(.MAX_RUN(MAX_RUN), .EVT_W(EVT_W)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  m_run;    // unbounded length of current run
  bit  m_last;
  bit  m_seen;   // a bit has been accepted since reset/clear
  int  m_thr;
  int  m_zero;
  int  m_one;
  bit  m_hit;
  int  m_out;

  function automatic int clamp_thr(input int rl);
    if (rl == 0) return 1;
    if (rl > MAX_RUN) return MAX_RUN;
    return rl;
  endfunction

  task automatic model_reset();
    m_run = 0; m_last = 0; m_seen = 0; m_thr = 1;
    m_zero = 0; m_one = 0; m_hit = 0; m_out = 0;
  endtask

  task automatic model_edge(input bit c, input bit e, input bit d, input int rl);
    if (c) begin
      m_seen = 0; m_run = 0; m_out = 0; m_hit = 0; m_zero = 0; m_one = 0;
    end else if (!e) begin
      m_hit = 0;
    end else begin
      if (!m_seen) m_thr = clamp_thr(rl);
      if (!m_seen || d != m_last) m_run = 1;
      else m_run = m_run + 1;
      m_last = d;
      m_seen = 1;
      m_hit  = (m_run == m_thr);
      if (m_hit) begin
        if (d) m_one  = (m_one  < EVT_MAX) ? m_one + 1  : m_one;
        else   m_zero = (m_zero < EVT_MAX) ? m_zero + 1 : m_zero;
      end
      m_out = (m_run >= m_thr) ? (d ? 2 : 1) : 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out"},  int'(bus.OUT), m_out);
    check({tag, ".hit"},  int'(bus.HIT), int'(m_hit));
    check({tag, ".cnt"},  int'(bus.RUN_CNT), (m_run > MAX_RUN) ? MAX_RUN : m_run);
    check({tag, ".zevt"}, int'(bus.ZERO_EVT_CNT), m_zero);
    check({tag, ".oevt"}, int'(bus.ONE_EVT_CNT), m_one);
  endtask

  // ---------------- drivers ----------------
  int rl;

  task automatic step(input bit c, input bit e, input bit d, input string tag);
    bus.CLR = c; bus.EN = e; bus.DATA = d; bus.RUN_LEN = CNT_W'(rl);
    @(posedge clk);
    model_edge(c, e, d, rl);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    bus.CLR = 0; bus.EN = 0; bus.DATA = 0; bus.RUN_LEN = CNT_W'(rl);
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    check_all("reset");
  endtask

  // Pull reset low between edges and confirm outputs clear before the next edge.
  task automatic async_reset_check();
    #3;
    rst_n = 0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit d;
    rst_n = 1;
    rl = 3;
    model_reset();
    do_reset();

    // zero run to threshold 3, then a one run
    step(0, 0, 0, "idle");
    for (int i = 0; i < 3; i++) step(0, 1, 0, "zeros");
    check("zrun.out_01", int'(bus.OUT), 1);
    check("zrun.hit", int'(bus.HIT), 1);
    check("zrun.zevt", int'(bus.ZERO_EVT_CNT), 1);
    step(0, 1, 1, "flip");
    check("flip.cnt1", int'(bus.RUN_CNT), 1);
    for (int i = 0; i < 2; i++) step(0, 1, 1, "ones");
    check("orun.out_10", int'(bus.OUT), 2);
    check("orun.oevt", int'(bus.ONE_EVT_CNT), 1);

    // saturation: twelve ones from a fresh start
    step(1, 0, 0, "clr");
    step(0, 0, 0, "idle");
    for (int i = 0; i < 12; i++) step(0, 1, 1, "sat");
    check("sat.cnt", int'(bus.RUN_CNT), MAX_RUN);
    check("sat.oevt", int'(bus.ONE_EVT_CNT), 1);

    // EN gaps hold everything, threshold 4
    rl = 4;
    step(1, 0, 0, "clr");
    step(0, 0, 0, "idle");
    for (int s = 0; s < 4; s++) begin
      step(0, 1, 1, "gap_smp");
      for (int g = 0; g < 5; g++) step(0, 0, $urandom_range(0, 1) != 0, "gap_hold");
    end
    check("gap.out_10", int'(bus.OUT), 2);

    // threshold 0 clamps to 1: every alternating sample hits
    rl = 0;
    step(1, 0, 0, "clr");
    step(0, 0, 0, "idle");
    for (int i = 0; i < 4; i++) step(0, 1, i[0], "alt");
    check("alt.zevt2", int'(bus.ZERO_EVT_CNT), 2);
    check("alt.oevt2", int'(bus.ONE_EVT_CNT), 2);

    // clear mid-run discards DATA
    rl = 3;
    step(1, 0, 0, "clr");
    step(0, 0, 0, "idle");
    step(0, 1, 1, "pre_clr");
    step(0, 1, 1, "pre_clr");
    step(1, 1, 1, "mid_clr");
    check("mid_clr.cnt0", int'(bus.RUN_CNT), 0);

    // async reset mid-run
    step(0, 0, 0, "idle");
    step(0, 1, 1, "pre_rst");
    step(0, 1, 1, "pre_rst");
    async_reset_check();
    step(0, 0, 0, "post_rst");

    // randomized stream, biased toward repeating bits to build long runs
    d = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) rl = $urandom_range(0, (1 << CNT_W) - 1);
      if ($urandom_range(0, 3) == 0) d = ~d;
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, d, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
